boot_loader: RTL
================

Name: boot_loader

Overview:
- Upstream stage of the single-cycle core. Receives a byte stream from the host or serial front end and writes the program image into instruction memory through its write port.
- Latches the entry PC for the core's fetch logic.
- Holds the core in reset until a complete, checksum-verified image is loaded, then releases it.

Parameters:
- DEPTH_WORDS, 1024, instruction-memory capacity in 32-bit words; a word count above this is an error.
- MAGIC, 8'hA5, frame start byte.
- ADDR_W, 64, width of the imem byte address and of the entry PC.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_valid  in  1  rx_data holds a byte
- rx_data  in  8  incoming byte
- rx_ready  out  1  loader accepts a byte this cycle
- imem_we  out  1  one-cycle instruction-memory write strobe
- imem_addr  out  ADDR_W  byte address of the write, word-aligned
- imem_wdata  out  32  instruction word
- boot_pc  out  ADDR_W  entry PC, valid while done=1
- cpu_reset  out  1  reset to the core, active-high
- done  out  1  image loaded and verified (sticky)
- error  out  1  load failed (sticky)

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-high.
- Reset values: rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, boot_pc=0, cpu_reset=1, done=0, error=0, state=IDLE.
- Handshake: a byte transfers on a rising clk edge with rx_valid & rx_ready. rx_ready=1 in IDLE, LEN, ENTRY, DATA and CSUM; 0 in DONE and ERROR. No backpressure inside a frame.
- Frame format, all multi-byte fields little-endian:
  - MAGIC
  - word count N, 2 bytes
  - entry PC, 8 bytes
  - N x 4-byte instruction words
  - 1 checksum byte
- Checksum = 8-bit modular sum of all bytes after MAGIC, up to but excluding the checksum byte.
- States:
  - IDLE: bytes other than MAGIC are discarded. MAGIC -> LEN; clear the byte counter and the checksum accumulator.
  - LEN: after 2 bytes, N is latched.
    - N > DEPTH_WORDS -> ERROR.
    - Otherwise -> ENTRY.
  - ENTRY: after 8 bytes, the entry PC is latched into an internal register. If N=0 -> CSUM, else -> DATA.
  - DATA: bytes are assembled LSB first into a 32-bit word.
    - On the cycle the 4th byte is accepted, imem_we is asserted at the next edge for exactly one cycle, with imem_wdata = the assembled word and imem_addr = 4*word_index.
    - word_index starts at 0 and increments after each write.
    - After word N-1 is written -> CSUM. The last write and the CSUM entry happen on the same edge.
  - CSUM: one byte is accepted.
    - Equal to the accumulator -> DONE.
    - Otherwise -> ERROR.
  - DONE: done=1 and boot_pc = latched entry PC, on the same edge. cpu_reset falls one cycle after done rises, so boot_pc is stable before the core leaves reset. Terminal until reset.
  - ERROR: error=1, cpu_reset stays 1, imem_we=0. Terminal until reset.
- Widths:
  - The word counter is wide enough to count to DEPTH_WORDS.
  - imem_addr is zero-extended to ADDR_W with bits [1:0]=0.
  - The checksum wraps mod 256.
- Boundaries:
  - N=DEPTH_WORDS is legal; the final write goes to 4*(DEPTH_WORDS-1).
  - A MAGIC byte appearing inside LEN, ENTRY, DATA or CSUM is payload, not a restart.
  - rx_valid=0 gaps at any point stall the FSM with no state change and no writes.
- Reset mid-load: the FSM returns to IDLE, outputs take their reset values, and cpu_reset=1. Partially written imem contents are not cleared; a new full frame overwrites them.

Decomposition:
- Shared package/header (params.vh): state encodings (IDLE, LEN, ENTRY, DATA, CSUM, DONE, ERROR), MAGIC default, header field byte counts (LEN_BYTES=2, ENTRY_BYTES=8, WORD_BYTES=4).
- One sub-module: boot_shift_asm, a little-endian byte-to-word shift register with byte counter, reused for LEN, ENTRY and DATA fields, plus running-sum output.
- FSM and imem write logic stay in boot_loader.

Test Plan:
- Normal frame: A5, 02 00, entry 00x8, words 8B000020 and D65F03C0, correct checksum.
  - imem_we pulses twice: addr 0 data 8B000020, then addr 4 data D65F03C0.
  - done=1, then cpu_reset=0 one cycle later, boot_pc=0.
- Bad checksum: same frame with the checksum byte +1 -> error=1, cpu_reset stays 1, done=0, rx_ready=0 afterwards.
- Oversize count: with DEPTH_WORDS=4, send A5, 05 00 -> ERROR right after the 2nd count byte, and no imem_we ever.
- Zero words with entry 0x0000000000001000: A5, 00 00, 00 10 00 00 00 00 00 00, checksum 0x10 -> done=1, boot_pc=64'h1000, no imem writes.
- Leading garbage and gaps: 00 FF 3C before A5, with random rx_valid=0 gaps and a 0xA5 byte inside a data word -> the word is written intact and done=1.
- Reset mid-DATA: assert reset after 5 data bytes.
  - All outputs return to reset values.
  - A following full frame loads correctly from addr 0.

Source files
------------

// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: FSM states, frame constants and
// field sizes used by the byte assembler and the top-level loader.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        ENTRY = 3'd2,
        DATA  = 3'd3,
        CSUM  = 3'd4,
        DONE  = 3'd5,
        ERROR = 3'd6
    } state_t;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

    localparam int LEN_BYTES   = 2;
    localparam int ENTRY_BYTES = 8;
    localparam int WORD_BYTES  = 4;

    // The assembler is sized for the widest field (the entry PC).
    localparam int FIELD_BYTES = 8;
    localparam int FIELD_CNT_W = 4;

endpackage

// File: rtl/boot_shift_asm.sv
// Little-endian byte-to-field assembler shared by the LEN, ENTRY and DATA
// fields, with a running 8-bit sum of every byte shifted in since clear.
module boot_shift_asm
    import boot_loader_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         shift,
    input  logic                         restart,
    input  logic [7:0]                   byte_in,
    output logic [8*FIELD_BYTES-1:0]     field_next,
    output logic [FIELD_CNT_W-1:0]       count,
    output logic [7:0]                   sum
);

    logic [8*FIELD_BYTES-1:0] field_q;

    // field_next already contains the byte being accepted this cycle, so the
    // owner can latch a completed field on the same edge as its last byte.
    always_comb begin
        field_next = field_q;
        for (int i = 0; i < FIELD_BYTES; i++) begin
            if (count == FIELD_CNT_W'(i)) begin
                field_next[i*8 +: 8] = byte_in;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            field_q <= '0;
            count   <= '0;
            sum     <= '0;
        end else if (clear) begin
            field_q <= '0;
            count   <= '0;
            sum     <= '0;
        end else if (shift) begin
            sum <= sum + byte_in;
            if (restart) begin
                field_q <= '0;
                count   <= '0;
            end else begin
                field_q <= field_next;
                count   <= count + FIELD_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Frame-parsing boot loader: writes a checksummed image into instruction
// memory, latches the entry PC and holds the core in reset until verified.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int         DEPTH_WORDS = 1024,
    parameter logic [7:0] MAGIC       = MAGIC_DEFAULT,
    parameter int         ADDR_W      = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W-1:0] boot_pc,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output state_t            state
);

    localparam int WC_W = $clog2(DEPTH_WORDS + 1);

    // Handshake: a byte moves on a rising edge where rx_valid & rx_ready.
    // rx_ready is registered and is high in every state except DONE/ERROR.

    state_t state_q, state_d;

    logic [WC_W-1:0]          n_words;
    logic [WC_W-1:0]          word_idx;
    logic [ADDR_W-1:0]        entry_pc;

    logic                     accept;
    logic                     asm_clear;
    logic                     asm_shift;
    logic                     asm_restart;
    logic [8*FIELD_BYTES-1:0] asm_next;
    logic [FIELD_CNT_W-1:0]   asm_count;
    logic [7:0]               asm_sum;

    logic                     latch_len;
    logic                     latch_pc;
    logic                     write_word;

    assign accept = rx_valid & rx_ready;
    assign state  = state_q;

    boot_shift_asm u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (asm_clear),
        .shift      (asm_shift),
        .restart    (asm_restart),
        .byte_in    (rx_data),
        .field_next (asm_next),
        .count      (asm_count),
        .sum        (asm_sum)
    );

    always_comb begin
        state_d     = state_q;
        asm_clear   = 1'b0;
        asm_shift   = 1'b0;
        asm_restart = 1'b0;
        latch_len   = 1'b0;
        latch_pc    = 1'b0;
        write_word  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept && rx_data == MAGIC) begin
                    asm_clear = 1'b1;
                    state_d   = LEN;
                end
            end
            LEN: begin
                if (accept) begin
                    asm_shift = 1'b1;
                    if (asm_count == FIELD_CNT_W'(LEN_BYTES - 1)) begin
                        asm_restart = 1'b1;
                        latch_len   = 1'b1;
                        if (32'(asm_next[15:0]) > 32'(DEPTH_WORDS)) begin
                            state_d = ERROR;
                        end else begin
                            state_d = ENTRY;
                        end
                    end
                end
            end
            ENTRY: begin
                if (accept) begin
                    asm_shift = 1'b1;
                    if (asm_count == FIELD_CNT_W'(ENTRY_BYTES - 1)) begin
                        asm_restart = 1'b1;
                        latch_pc    = 1'b1;
                        state_d     = (n_words == '0) ? CSUM : DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    asm_shift = 1'b1;
                    if (asm_count == FIELD_CNT_W'(WORD_BYTES - 1)) begin
                        asm_restart = 1'b1;
                        write_word  = 1'b1;
                        if (word_idx + WC_W'(1) == n_words) begin
                            state_d = CSUM;
                        end
                    end
                end
            end
            CSUM: begin
                if (accept) begin
                    state_d = (rx_data == asm_sum) ? DONE : ERROR;
                end
            end
            DONE:    state_d = DONE;
            ERROR:   state_d = ERROR;
            default: state_d = ERROR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rx_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            boot_pc    <= '0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            n_words    <= '0;
            word_idx   <= '0;
            entry_pc   <= '0;
        end else begin
            state_q  <= state_d;
            rx_ready <= (state_d != DONE) && (state_d != ERROR);
            imem_we  <= write_word;

            if (asm_clear) begin
                word_idx <= '0;
            end else if (write_word) begin
                imem_addr  <= ADDR_W'({word_idx, 2'b00});
                imem_wdata <= asm_next[31:0];
                word_idx   <= word_idx + WC_W'(1);
            end

            if (latch_len) begin
                n_words <= WC_W'(asm_next[15:0]);
            end
            if (latch_pc) begin
                entry_pc <= ADDR_W'(asm_next);
            end

            if (state_d == DONE && state_q != DONE) begin
                done    <= 1'b1;
                boot_pc <= entry_pc;
            end
            if (state_d == ERROR) begin
                error <= 1'b1;
            end

            // Lags done by one edge so boot_pc is settled when the core starts.
            cpu_reset <= ~done;
        end
    end

endmodule
